// File: rtl/iter_muldiv_if.sv
// Handshake and operand bundle between the Execute stage and the iterative mul/div unit.
interface iter_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, opcode, operand1, operand2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, opcode, operand1, operand2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with single-cycle special-case completion for x/0 and MIN/-1.
module iter_muldiv #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input logic         clk,
  input logic         rst,
  iter_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic                neg_q;
  logic                special_q;
  logic [XLEN-1:0]     spec_q;
  logic [XLEN-1:0]     dvsr_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     result_q;
  logic                busy_q;
  logic                done_q;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand decode for the request presented in IDLE
  logic            s1_signed, s2_signed, is_div, sign1, sign2, divz, ovf, neg_d;
  logic [XLEN-1:0] mag1, mag2, spec_d;

  always_comb begin
    is_div    = bus.opcode[2];
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    case (bus.opcode)
      3'b001, 3'b100, 3'b110: begin
        s1_signed = 1'b1;
        s2_signed = 1'b1;
      end
      3'b010:  s1_signed = 1'b1;
      default: ;
    endcase
    sign1  = s1_signed & bus.operand1[XLEN-1];
    sign2  = s2_signed & bus.operand2[XLEN-1];
    mag1   = mag(bus.operand1, s1_signed);
    mag2   = mag(bus.operand2, s2_signed);
    // A remainder takes the dividend's sign; products and quotients take the XOR.
    neg_d  = (is_div && bus.opcode[1]) ? sign1 : (sign1 ^ sign2);
    divz   = is_div && (bus.operand2 == '0);
    ovf    = is_div && s1_signed && (bus.operand1 == SMIN) && (bus.operand2 == '1);
    if (divz) spec_d = bus.opcode[1] ? bus.operand1 : '1;
    else      spec_d = bus.opcode[1] ? '0 : SMIN;
  end

  // One iteration step for either algorithm
  logic [XLEN:0]     add_sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, dvsr_q};
    if (op_q[2]) begin
      if (diff[XLEN]) acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else            acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   final_d;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    case (op_q)
      3'b000:                 final_d = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_d = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_d = neg_if(acc_q[XLEN-1:0], neg_q);
      default:                final_d = neg_if(acc_q[2*XLEN-1:XLEN], neg_q);
    endcase
    if (special_q) final_d = spec_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      spec_q    <= '0;
      dvsr_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              op_q      <= bus.opcode;
              neg_q     <= neg_d;
              special_q <= divz | ovf;
              spec_q    <= spec_d;
              dvsr_q    <= is_div ? mag2 : mag1;
              acc_q     <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
              // Fast path skips the iterations by starting the counter at its end.
              cnt_q     <= (FAST_SPECIAL && (divz || ovf)) ? CW'(XLEN) : '0;
              state_q   <= RUN;
              busy_q    <= 1'b1;
            end
          end
          RUN: begin
            if (cnt_q == CW'(XLEN)) begin
              result_q <= final_d;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              acc_q <= acc_step;
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Bench for iter_muldiv: directed vector table, multi-cycle corner sequences,
// and randomized operations against a plain-arithmetic RV32M reference.
module tb_iter_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iter_muldiv_if #(.XLEN(XLEN)) bus();
  iter_muldiv #(.XLEN(XLEN), .FAST_SPECIAL(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    logic ovf;
    sa  = 64'(signed'(a));
    sb  = 64'(signed'(b));
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_n);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.operand1 = a; bus.operand2 = b;
    @(negedge clk);
    bus.start = 1'b0; bus.opcode = 3'($urandom); bus.operand1 = $urandom; bus.operand2 = $urandom;
    lat = 1; busy_n = 0;
    while (1) begin
      if (bus.busy) busy_n++;
      if (bus.done || lat >= 100) break;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    @(negedge clk);
    check("done_single_pulse", 32'(bus.done), 32'd0);
    check("busy_low_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int lat, bn, dn;

    rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
    bus.opcode = '0; bus.operand1 = '0; bus.operand2 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;

    vecs.push_back('{"mul_7_m3",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{"mulh_min_m1",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34});
    vecs.push_back('{"mulhsu_min",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
    vecs.push_back('{"mulhu_big",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34});
    vecs.push_back('{"div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
    vecs.push_back('{"rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
    vecs.push_back('{"divu_100_7",    3'd5, 32'd100,       32'd7,         32'd14,        34});
    vecs.push_back('{"remu_100_7",    3'd7, 32'd100,       32'd7,         32'd2,         34});
    vecs.push_back('{"div_by0",       3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 2});
    vecs.push_back('{"divu_by0",      3'd5, 32'hDEAD_BEEF, 32'd0,         32'hFFFF_FFFF, 2});
    vecs.push_back('{"remu_by0",      3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, 2});
    vecs.push_back('{"rem_by0_neg",   3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2});
    vecs.push_back('{"div_overflow",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
    vecs.push_back('{"rem_overflow",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2});
    vecs.push_back('{"divu_min_m1",   3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34});

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bn);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_busy_cycles"}, 32'(bn), 32'(vecs[i].lat));
    end

    // Flush part-way through a DIVU together with a new start request
    do_op(3'd0, 32'd6, 32'd7, res, lat, bn);
    check("pre_flush_mul", res, 32'd42);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd5; bus.operand1 = 32'd1000; bus.operand2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1; bus.opcode = 3'd0; bus.operand1 = 32'd9; bus.operand2 = 32'd9;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_result_kept", bus.result, 32'd42);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("flush_no_done", 32'(dn), 32'd0);
    check("flush_result_still", bus.result, 32'd42);
    do_op(3'd0, 32'd3, 32'd5, res, lat, bn);
    check("post_flush_mul", res, 32'd15);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd0; bus.operand1 = 32'h0001_2345; bus.operand2 = 32'h0000_0777;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(bus.busy), 32'd0);
    check("midrun_rst_done", 32'(bus.done), 32'd0);
    check("midrun_rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // A start pulse while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd5; bus.operand1 = 32'd100; bus.operand2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'd0; bus.operand1 = 32'd3; bus.operand2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    dn = 0; res = '0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        res = bus.result;
      end
    end
    check("busy_start_done_count", 32'(dn), 32'd1);
    check("busy_start_result", res, 32'd14);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          el;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      el = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 34;
      do_op(op, a, b, res, lat, bn);
      check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), res, ref_op(op, a, b));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(el));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
